// File: rtl/seg7_msg_if.sv
// Control and display bundle between the top-level buttons/switches, the
// message sequencer and the 7-segment decoder.
interface seg7_msg_if;
  logic       start;
  logic       stop;
  logic       pause;
  logic       loop_en;
  logic [3:0] counter;
  logic       busy;
  logic       step_strobe;
  logic       done;

  modport master (
    output start, stop, pause, loop_en,
    input  counter, busy, step_strobe, done
  );

  modport slave (
    input  start, stop, pause, loop_en,
    output counter, busy, step_strobe, done
  );
endinterface

// File: rtl/seg7_msg_sequencer.sv
// Steps the decoder code through FIRST_CODE..LAST_CODE at one step per TICK_DIV
// clocks, with optional looping and a blank gap of GAP_TICKS steps between passes.
module seg7_msg_sequencer #(
  parameter int TICK_DIV   = 10_000_000,
  parameter int FIRST_CODE = 1,
  parameter int LAST_CODE  = 7,
  parameter int GAP_TICKS  = 2
) (
  input  logic       clk,
  input  logic       rst,
  seg7_msg_if.slave  bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_LAST);
  localparam logic [3:0]    FIRST_C  = 4'(FIRST_CODE);
  localparam logic [3:0]    LAST_C   = 4'(LAST_CODE);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]    state_q,   state_d;
  logic [3:0]    counter_q, counter_d;
  logic [PW-1:0] presc_q,   presc_d;
  logic [GW-1:0] gap_q,     gap_d;
  logic          strobe_q,  strobe_d;
  logic          done_q,    done_d;
  logic          busy_q;
  logic          tick_s;

  assign tick_s = (presc_q == TICK_MAX);

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    presc_d   = presc_q;
    gap_d     = gap_q;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    if (bus.stop) begin
      state_d   = ST_IDLE;
      counter_d = 4'd0;
      presc_d   = '0;
      gap_d     = '0;
    end else if (bus.start) begin
      state_d   = ST_SHOW;
      counter_d = FIRST_C;
      presc_d   = '0;
      gap_d     = '0;
    end else if (state_q == ST_IDLE) begin
      counter_d = 4'd0;
      presc_d   = '0;
    end else if (bus.pause) begin
      presc_d = presc_q;
    end else begin
      presc_d = tick_s ? '0 : presc_q + PW'(1);
      if (tick_s) begin
        case (state_q)
          ST_SHOW: begin
            strobe_d = 1'b1;
            if (counter_q < LAST_C) begin
              counter_d = counter_q + 4'd1;
            end else if (bus.loop_en && (GAP_TICKS > 0)) begin
              state_d   = ST_GAP;
              counter_d = 4'd0;
              gap_d     = '0;
            end else if (bus.loop_en) begin
              counter_d = FIRST_C;
            end else begin
              state_d   = ST_IDLE;
              counter_d = 4'd0;
              done_d    = 1'b1;
            end
          end
          ST_GAP: begin
            // The gap always runs to completion; loop_en is only consulted at end of pass.
            if (gap_q == GAP_MAX) begin
              state_d   = ST_SHOW;
              counter_d = FIRST_C;
              gap_d     = '0;
              strobe_d  = 1'b1;
            end else begin
              gap_d = gap_q + GW'(1);
            end
          end
          default: begin
            state_d   = ST_IDLE;
            counter_d = 4'd0;
            presc_d   = '0;
          end
        endcase
      end else begin
        counter_d = counter_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      counter_q <= 4'd0;
      presc_q   <= '0;
      gap_q     <= '0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      presc_q   <= presc_d;
      gap_q     <= gap_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign bus.counter     = counter_q;
  assign bus.busy        = busy_q;
  assign bus.step_strobe = strobe_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_seg7_msg_sequencer.sv
// Self-checking bench for seg7_msg_sequencer: directed scenarios plus random
// control traffic compared against a step-list reference model.
module tb_seg7_msg_sequencer;

  localparam int TD = 4;
  localparam int FC = 1;
  localparam int LC = 7;
  localparam int GT = 2;
  localparam int NC = LC - FC + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_msg_if bus ();
  seg7_msg_if bus2 ();

  seg7_msg_sequencer #(.TICK_DIV(TD), .FIRST_CODE(FC), .LAST_CODE(LC), .GAP_TICKS(GT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  seg7_msg_sequencer #(.TICK_DIV(1), .FIRST_CODE(FC), .LAST_CODE(LC), .GAP_TICKS(0)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a pass is a list of steps (NC codes, then GT blanks when
  // looping); each step lasts TD unpaused cycles.
  bit m_active = 1'b0;
  int m_idx     = 0;
  int m_elapsed = 0;
  bit m_strobe  = 1'b0;
  bit m_done    = 1'b0;

  function automatic logic [6:0] exp_vec();
    logic [3:0] c;
    c = (m_active && m_idx < NC) ? 4'(FC + m_idx) : 4'd0;
    return {c, m_active, m_strobe, m_done};
  endfunction

  function automatic logic [6:0] obs_vec();
    return {bus.counter, bus.busy, bus.step_strobe, bus.done};
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_idx = 0; m_elapsed = 0; m_strobe = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_edge(input bit s, input bit st, input bit p, input bit l);
    m_strobe = 1'b0;
    m_done   = 1'b0;
    if (s) begin
      m_active = 1'b0; m_idx = 0; m_elapsed = 0;
    end else if (st) begin
      m_active = 1'b1; m_idx = 0; m_elapsed = 0;
    end else if (m_active && !p) begin
      m_elapsed++;
      if (m_elapsed == TD) begin
        m_elapsed = 0;
        if (m_idx < NC - 1) begin
          m_idx++; m_strobe = 1'b1;
        end else if (m_idx == NC - 1) begin
          m_strobe = 1'b1;
          if (!l) begin
            m_active = 1'b0; m_done = 1'b1; m_idx = 0;
          end else if (GT > 0) begin
            m_idx++;
          end else begin
            m_idx = 0;
          end
        end else if (m_idx == NC + GT - 1) begin
          m_idx = 0; m_strobe = 1'b1;
        end else begin
          m_idx++;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(bus.stop, bus.start, bus.pause, bus.loop_en);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if (obs_vec() !== 7'd0) $display("FAIL reset_async got=%h want=%h", obs_vec(), 7'd0);
    else n_pass++;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cycle();
    n_total++;
    if (obs_vec() !== exp_vec()) $display("FAIL reset_idle got=%h want=%h", obs_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_single_pass();
    int strobes = 0;
    int dones = 0;
    bus.loop_en = 1'b0;
    pulse_start();
    n_total++;
    if (bus.counter !== 4'd1) $display("FAIL single_first got=%0d want=1", bus.counter);
    else n_pass++;
    for (int i = 1; i <= 28; i++) begin
      cycle();
      strobes += int'(bus.step_strobe);
      dones   += int'(bus.done);
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL single_pass c%0d got=%h want=%h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_total++;
    if (obs_vec() !== {4'd0, 1'b0, 1'b1, 1'b1}) $display("FAIL single_end got=%h want=%h", obs_vec(), {4'd0, 1'b0, 1'b1, 1'b1});
    else n_pass++;
    n_total++;
    if (strobes !== 7) $display("FAIL single_strobes got=%0d want=7", strobes);
    else n_pass++;
    n_total++;
    if (dones !== 1) $display("FAIL single_dones got=%0d want=1", dones);
    else n_pass++;
    cycle();
    n_total++;
    if (obs_vec() !== 7'd0) $display("FAIL single_after got=%h want=0", obs_vec());
    else n_pass++;
  endtask

  task automatic test_loop_gap();
    int busy_low = 0;
    int dones = 0;
    bus.loop_en = 1'b1;
    pulse_start();
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (!bus.busy) busy_low++;
      if (bus.done) dones++;
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL loop_gap c%0d got=%h want=%h", i, obs_vec(), exp_vec());
      else n_pass++;
      if (i == 28) begin
        n_total++;
        if (bus.counter !== 4'd0) $display("FAIL loop_gap_blank got=%0d want=0", bus.counter);
        else n_pass++;
      end
      if (i == 36) begin
        n_total++;
        if (bus.counter !== 4'd1) $display("FAIL loop_gap_restart got=%0d want=1", bus.counter);
        else n_pass++;
      end
    end
    n_total++;
    if (busy_low !== 0 || dones !== 0) $display("FAIL loop_gap_busy busy_low=%0d dones=%0d want 0,0", busy_low, dones);
    else n_pass++;
    pulse_stop();
    bus.loop_en = 1'b0;
  endtask

  task automatic test_pause();
    int n = 0;
    bus.loop_en = 1'b0;
    pulse_start();
    while (bus.counter !== 4'd3 && n < 50) begin cycle(); n++; end
    n_total++;
    if (n >= 50) $display("FAIL pause_reach3 got=%0d want=3", bus.counter);
    else n_pass++;
    cycle(); cycle();
    bus.pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_total++;
      if (bus.counter !== 4'd3 || obs_vec() !== exp_vec()) $display("FAIL pause_hold c%0d got=%h want=%h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    bus.pause = 1'b0;
    n = 0;
    while (bus.counter !== 4'd4 && n < 20) begin cycle(); n++; end
    n_total++;
    if (n !== 2) $display("FAIL pause_resume got=%0d cycles want=2", n);
    else n_pass++;
    pulse_stop();
  endtask

  task automatic test_abort();
    int n = 0;
    pulse_start();
    while (bus.counter !== 4'd5 && n < 50) begin cycle(); n++; end
    pulse_stop();
    n_total++;
    if (obs_vec() !== 7'd0 || obs_vec() !== exp_vec()) $display("FAIL abort_stop got=%h want=0", obs_vec());
    else n_pass++;
    bus.stop = 1'b1; bus.start = 1'b1;
    cycle();
    bus.stop = 1'b0; bus.start = 1'b0;
    cycle();
    n_total++;
    if (obs_vec() !== 7'd0) $display("FAIL abort_stop_start got=%h want=0", obs_vec());
    else n_pass++;
    pulse_start();
    n = 0;
    while (bus.counter !== 4'd5 && n < 50) begin cycle(); n++; end
    pulse_start();
    n_total++;
    if (bus.counter !== 4'd1 || obs_vec() !== exp_vec()) $display("FAIL abort_restart got=%h want=%h", obs_vec(), exp_vec());
    else n_pass++;
    for (int i = 0; i < 4; i++) cycle();
    n_total++;
    if (bus.counter !== 4'd2 || bus.step_strobe !== 1'b1) $display("FAIL abort_presc got=%0d/%0d want=2/1", bus.counter, bus.step_strobe);
    else n_pass++;
    pulse_stop();
  endtask

  task automatic test_async_reset();
    int n = 0;
    bus.loop_en = 1'b0;
    pulse_start();
    while (bus.counter !== 4'd6 && n < 50) begin cycle(); n++; end
    #3 rst = 1'b1;
    #1;
    n_total++;
    if (bus.counter !== 4'd0 || bus.busy !== 1'b0) $display("FAIL async_reset got=%0d/%0d want=0/0", bus.counter, bus.busy);
    else n_pass++;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_total++;
      if (obs_vec() !== 7'd0 || obs_vec() !== exp_vec()) $display("FAIL async_idle c%0d got=%h want=0", i, obs_vec());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.start = ($urandom_range(0, 19) == 0);
      bus.stop  = ($urandom_range(0, 39) == 0);
      bus.pause = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 29) == 0) bus.loop_en = ~bus.loop_en;
      cycle();
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL random c%0d got=%h want=%h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    bus.start = 1'b0; bus.pause = 1'b0;
    pulse_stop();
  endtask

  task automatic test_edge_params();
    bus2.loop_en = 1'b1;
    bus2.start   = 1'b1;
    cycle();
    bus2.start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      n_total++;
      if ({bus2.counter, bus2.busy, bus2.step_strobe} !== {4'(FC + (k % NC)), 1'b1, (k > 0)})
        $display("FAIL edge_params k%0d got=%0d/%0d/%0d want=%0d/1/%0d", k, bus2.counter, bus2.busy,
                 bus2.step_strobe, FC + (k % NC), (k > 0));
      else n_pass++;
      cycle();
    end
    bus2.stop = 1'b1;
    cycle();
    bus2.stop = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0; bus.loop_en = 1'b0;
    bus2.start = 1'b0; bus2.stop = 1'b0; bus2.pause = 1'b0; bus2.loop_en = 1'b0;
    test_reset();
    test_single_pass();
    test_loop_gap();
    test_pause();
    test_abort();
    test_async_reset();
    test_random();
    test_edge_params();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
